// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller.
//   - opcode constants decoded from INSTRUCTION[31:26]
//   - ALUOp, ALU source-B and PC-source mux encodings
//   - 4-bit FSM state encodings (also exported on the debug state output)
//   - is_mem_state(): true for states that issue a memory request and wait
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_J     = 6'd2;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BEQ_EX   = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath.
//   Datapath -> controller: opcode, zero, mem_ready
//   Controller -> datapath: PC/IR/regfile enables, mux selects, memory
//   requests, status pulses (instr_done, illegal_op, mem_timeout), debug state.
// Memory handshake: mem_read / mem_write is a request held high, unchanged,
// until the memory answers with mem_ready=1 in the same cycle; the access
// completes in exactly that cycle. mem_ready while no request is up is ignored.
// The two requests are never high together.
interface multicycle_controller_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_timeout;
    logic [3:0] state;

    // Controller side: drives every control line.
    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, illegal_op, mem_timeout, state
    );

    // Datapath / memory side.
    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, illegal_op, mem_timeout, state
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready.
//   clk_i, rst_i : clock, synchronous active-high reset (count -> 0)
//   clr_i        : clear count (has priority over inc_i)
//   inc_i        : one more waiting cycle has elapsed
//   expired_o    : the current waiting cycle is the LIMIT-th one
module mem_wait_timer #(
    parameter int LIMIT = 16,
    parameter int CNT_W = 5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of earlier waiting cycles, so the LIMIT-th
    // waiting cycle is the one that sees LIMIT-1.
    assign expired_o = (cnt_q == CNT_W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS sequencer: steps every instruction through FETCH, DECODE
// and an opcode-specific tail, driving datapath enables and mux selects
// state by state.
//   CLK, RESET : clock, synchronous active-high reset
//   bus        : controller side of multicycle_controller_if (inputs opcode,
//                zero, mem_ready; all control, status and debug outputs)
// Outputs are decoded from the state; FETCH and MEMWR also look at mem_ready
// so that IR/PC loads and completion happen only in the cycle memory answers.
// While RESET is high every output (including state) reads 0, which abandons
// any access in flight without a write.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic                    CLK,
    input  logic                    RESET,
    multicycle_controller_if.master bus
);
    state_t state_q, state_d;
    logic   waiting;
    logic   timeout;
    logic   timer_expired;
    logic   timer_clr;

    assign waiting   = is_mem_state(state_q) && !bus.mem_ready;
    assign timeout   = waiting && timer_expired;
    // Clearing whenever we are not waiting covers both "on mem_ready" and
    // "on entry"; a timed-out FETCH re-enters itself, so clear on that too.
    assign timer_clr = !waiting || timeout || (state_d != state_q);

    mem_wait_timer #(
        .LIMIT (MEM_TIMEOUT),
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .clr_i     (timer_clr),
        .inc_i     (waiting),
        .expired_o (timer_expired)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.state = RESET ? 4'd0 : state_q;

    always_comb begin
        state_d           = state_q;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_B;
        bus.alu_op        = ALUOP_ADD;
        bus.pc_source     = PCSRC_ALU;
        bus.instr_done    = 1'b0;
        bus.illegal_op    = 1'b0;
        bus.mem_timeout   = timeout;

        case (state_q)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_d      = S_DECODE;
                end
                // On timeout stay in FETCH; the PC is not loaded.
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                bus.alu_src_b = SRCB_IMM_SH;
                case (bus.opcode)
                    OP_RTYPE:     state_d = S_RTYPE_EX;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BEQ_EX;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        bus.illegal_op = 1'b1;
                        state_d        = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                state_d       = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout) begin
                    state_d = S_FETCH;
                end
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEMWR: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
                if (bus.mem_ready) begin
                    bus.instr_done = 1'b1;
                    state_d        = S_FETCH;
                end else if (timeout) begin
                    state_d = S_FETCH;
                end
            end
            S_RTYPE_EX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALUOP_FUNCT;
                state_d       = S_RTYPE_WB;
            end
            S_RTYPE_WB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_BEQ_EX: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = ALUOP_SUB;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = PCSRC_ALUOUT;
                bus.instr_done    = 1'b1;
                state_d           = S_FETCH;
            end
            S_ADDI_EX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                state_d       = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_write   = 1'b1;
                bus.pc_source  = PCSRC_JUMP;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        if (RESET) begin
            bus.pc_write      = 1'b0;
            bus.pc_write_cond = 1'b0;
            bus.i_or_d        = 1'b0;
            bus.mem_read      = 1'b0;
            bus.mem_write     = 1'b0;
            bus.ir_write      = 1'b0;
            bus.reg_dst       = 1'b0;
            bus.mem_to_reg    = 1'b0;
            bus.reg_write     = 1'b0;
            bus.alu_src_a     = 1'b0;
            bus.alu_src_b     = SRCB_B;
            bus.alu_op        = ALUOP_ADD;
            bus.pc_source     = PCSRC_ALU;
            bus.instr_done    = 1'b0;
            bus.illegal_op    = 1'b0;
            bus.mem_timeout   = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: every cycle is stepped explicitly
// with a hand-written expected state and control word; a latency scoreboard
// checks the cycle count of each completed instruction.
module tb_multicycle_controller;
    import mips_ctrl_pkg::*;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       rd;
        logic       m2r;
        logic       rw;
        logic       asa;
        logic [1:0] asb;
        logic [1:0] aop;
        logic [1:0] psrc;
        logic       done;
        logic       ill;
        logic       tmo;
    } ctl_t;

    logic CLK = 1'b0;
    logic RESET;
    logic [5:0] cur_op;
    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    ctl_t e_zero, e_fetch, e_fwait, e_ftmo, e_decode, e_ill, e_madr, e_mrd;
    ctl_t e_mwb, e_mwr_done, e_mwr_wait, e_rex, e_rwb, e_beq, e_aex, e_awb;
    ctl_t e_jump;

    always #5 CLK = ~CLK;

    multicycle_controller_if bus();

    multicycle_controller #(
        .MEM_TIMEOUT (16),
        .CNT_W       (5)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.master)
    );

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    function automatic ctl_t observe();
        ctl_t c;
        c.pcw  = bus.pc_write;
        c.pcwc = bus.pc_write_cond;
        c.iord = bus.i_or_d;
        c.mr   = bus.mem_read;
        c.mw   = bus.mem_write;
        c.irw  = bus.ir_write;
        c.rd   = bus.reg_dst;
        c.m2r  = bus.mem_to_reg;
        c.rw   = bus.reg_write;
        c.asa  = bus.alu_src_a;
        c.asb  = bus.alu_src_b;
        c.aop  = bus.alu_op;
        c.psrc = bus.pc_source;
        c.done = bus.instr_done;
        c.ill  = bus.illegal_op;
        c.tmo  = bus.mem_timeout;
        return c;
    endfunction

    task automatic init_exp();
        e_zero = '0;
        e_fwait = '0;     e_fwait.mr = 1; e_fwait.asb = 2'd1;
        e_fetch = e_fwait; e_fetch.irw = 1; e_fetch.pcw = 1;
        e_ftmo = e_fwait; e_ftmo.tmo = 1;
        e_decode = '0;    e_decode.asb = 2'd3;
        e_ill = e_decode; e_ill.ill = 1;
        e_madr = '0;      e_madr.asa = 1; e_madr.asb = 2'd2;
        e_mrd = '0;       e_mrd.mr = 1; e_mrd.iord = 1;
        e_mwb = '0;       e_mwb.rw = 1; e_mwb.m2r = 1; e_mwb.done = 1;
        e_mwr_wait = '0;  e_mwr_wait.mw = 1; e_mwr_wait.iord = 1;
        e_mwr_done = e_mwr_wait; e_mwr_done.done = 1;
        e_rex = '0;       e_rex.asa = 1; e_rex.aop = 2'd2;
        e_rwb = '0;       e_rwb.rw = 1; e_rwb.rd = 1; e_rwb.done = 1;
        e_beq = '0;       e_beq.asa = 1; e_beq.aop = 2'd1; e_beq.pcwc = 1;
                          e_beq.psrc = 2'd1; e_beq.done = 1;
        e_aex = '0;       e_aex.asa = 1; e_aex.asb = 2'd2;
        e_awb = '0;       e_awb.rw = 1; e_awb.done = 1;
        e_jump = '0;      e_jump.pcw = 1; e_jump.psrc = 2'd2; e_jump.done = 1;
    endtask

    // One clock cycle: drive inputs at the falling edge, check settled outputs.
    task automatic step(input string tag, input logic rst, input logic rdy,
                        input logic [3:0] es, input ctl_t ec);
        @(negedge CLK);
        RESET = rst;
        bus.opcode = cur_op;
        bus.mem_ready = rdy;
        #1;
        check_val({tag, "_state"}, {28'd0, bus.state}, {28'd0, es});
        check_val({tag, "_ctl"}, {12'd0, observe()}, {12'd0, ec});
    endtask

    // Latency scoreboard: cycles from the first FETCH cycle to instr_done.
    initial begin
        int cnt;
        logic [7:0] want;
        cnt = 0;
        forever begin
            @(negedge CLK);
            #2;
            if (RESET) begin
                cnt = 0;
            end else begin
                cnt++;
                if (bus.instr_done) begin
                    want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'd0;
                    check_val("latency", cnt, {24'd0, want});
                    cnt = 0;
                end else if (bus.illegal_op || bus.mem_timeout) begin
                    cnt = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        init_exp();
        RESET = 1'b1;
        cur_op = OP_RTYPE;
        bus.opcode = OP_RTYPE;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;

        step("rst_a", 1, 0, S_FETCH, e_zero);
        step("rst_b", 1, 0, S_FETCH, e_zero);

        // R-type; mem_ready low outside memory states must be ignored
        cur_op = OP_RTYPE; exp_q.push_back(8'd4);
        step("r_f", 0, 1, S_FETCH, e_fetch);
        step("r_d", 0, 0, S_DECODE, e_decode);
        step("r_ex", 0, 1, S_RTYPE_EX, e_rex);
        step("r_wb", 0, 0, S_RTYPE_WB, e_rwb);

        // lw with three stall cycles in MEMRD
        cur_op = OP_LW; exp_q.push_back(8'd8);
        step("lw_f", 0, 1, S_FETCH, e_fetch);
        step("lw_d", 0, 1, S_DECODE, e_decode);
        step("lw_adr", 0, 1, S_MEMADR, e_madr);
        for (int i = 0; i < 3; i++) step("lw_stall", 0, 0, S_MEMRD, e_mrd);
        step("lw_rd", 0, 1, S_MEMRD, e_mrd);
        step("lw_wb", 0, 1, S_MEMWB, e_mwb);

        // sw
        cur_op = OP_SW; exp_q.push_back(8'd4);
        step("sw_f", 0, 1, S_FETCH, e_fetch);
        step("sw_d", 0, 1, S_DECODE, e_decode);
        step("sw_adr", 0, 1, S_MEMADR, e_madr);
        step("sw_wr", 0, 1, S_MEMWR, e_mwr_done);

        // beq taken and not taken: controller output is identical
        for (int z = 1; z >= 0; z--) begin
            cur_op = OP_BEQ; bus.zero = z[0]; exp_q.push_back(8'd3);
            step("beq_f", 0, 1, S_FETCH, e_fetch);
            step("beq_d", 0, 1, S_DECODE, e_decode);
            step("beq_ex", 0, 1, S_BEQ_EX, e_beq);
        end

        // addi
        cur_op = OP_ADDI; exp_q.push_back(8'd4);
        step("addi_f", 0, 1, S_FETCH, e_fetch);
        step("addi_d", 0, 1, S_DECODE, e_decode);
        step("addi_ex", 0, 1, S_ADDI_EX, e_aex);
        step("addi_wb", 0, 1, S_ADDI_WB, e_awb);

        // j
        cur_op = OP_J; exp_q.push_back(8'd3);
        step("j_f", 0, 1, S_FETCH, e_fetch);
        step("j_d", 0, 1, S_DECODE, e_decode);
        step("j_jmp", 0, 1, S_JUMP, e_jump);

        // illegal opcode: pulse in DECODE, straight back to FETCH
        cur_op = 6'd63;
        step("ill_f", 0, 1, S_FETCH, e_fetch);
        step("ill_d", 0, 1, S_DECODE, e_ill);

        // FETCH timeout: 15 plain waits, pulse on the 16th, PC never loaded
        cur_op = OP_J;
        for (int i = 0; i < 15; i++) step("tmo_wait", 0, 0, S_FETCH, e_fwait);
        step("tmo_pulse", 0, 0, S_FETCH, e_ftmo);
        exp_q.push_back(8'd3);
        step("tmo_refetch", 0, 1, S_FETCH, e_fetch);
        step("tmo_d", 0, 1, S_DECODE, e_decode);
        step("tmo_j", 0, 1, S_JUMP, e_jump);

        // RESET for two cycles in the middle of a stalled store
        cur_op = OP_SW;
        step("rw_f", 0, 1, S_FETCH, e_fetch);
        step("rw_d", 0, 1, S_DECODE, e_decode);
        step("rw_adr", 0, 1, S_MEMADR, e_madr);
        step("rw_wait", 0, 0, S_MEMWR, e_mwr_wait);
        step("rw_rst_a", 1, 1, S_FETCH, e_zero);
        step("rw_rst_b", 1, 1, S_FETCH, e_zero);
        cur_op = OP_J; exp_q.push_back(8'd4);
        step("rw_post", 0, 0, S_FETCH, e_fwait);
        step("rw_post_f", 0, 1, S_FETCH, e_fetch);
        step("rw_post_d", 0, 1, S_DECODE, e_decode);
        step("rw_post_j", 0, 1, S_JUMP, e_jump);

        @(negedge CLK);
        #3;
        check_val("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
